// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of one single-port on-chip RAM.
// One grant per cycle; read data returns one cycle after acceptance, tagged per master.
module onchip_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic       r_active;
  logic       r_last_grant;
  logic [1:0] r_rdv;
  logic       w_req0;
  logic       w_req1;
  logic       w_gnt0;
  logic       w_gnt1;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // On a tie, round-robin hands the slot to whichever master did not win last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_active) begin
      if (w_req0 && w_req1) begin
        if ((FIXED_PRIO != 0) || r_last_grant) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else begin
        w_gnt0 = w_req0;
        w_gnt1 = w_req1;
      end
    end
  end

  // A read+write from one master is a write, so it never produces readdatavalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active     <= 1'b0;
      r_last_grant <= 1'b1;
      r_rdv        <= 2'b00;
    end else begin
      r_active <= 1'b1;
      if (w_gnt0) begin
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_last_grant <= 1'b1;
      end
      r_rdv[0] <= w_gnt0 & m0_read & ~m0_write;
      r_rdv[1] <= w_gnt1 & m1_read & ~m1_write;
    end
  end

  assign m0_waitrequest   = ~w_gnt0;
  assign m1_waitrequest   = ~w_gnt1;
  assign m0_readdatavalid = r_rdv[0];
  assign m1_readdatavalid = r_rdv[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_address    = w_gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_gnt0 | w_gnt1;
  assign mem_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: one round-robin and one fixed-priority instance share
// the same master stimulus, each with its own RAM and its own reference model.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;

  logic        wt0 [2];
  logic        wt1 [2];
  logic        rv0 [2];
  logic        rv1 [2];
  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic [9:0]  mem_addr [2];
  logic [3:0]  mem_be [2];
  logic        mem_cs [2];
  logic        mem_we [2];
  logic [31:0] mem_wd [2];
  logic        mem_ck [2];
  logic [31:0] mem_rd [2];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [31:0] ram [0:1023];
      logic [9:0]  addr_q = '0;

      onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(gi)) u_dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(wt0[gi]),
        .m0_readdata(rd0[gi]), .m0_readdatavalid(rv0[gi]),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(wt1[gi]),
        .m1_readdata(rd1[gi]), .m1_readdatavalid(rv1[gi]),
        .mem_address(mem_addr[gi]), .mem_byteenable(mem_be[gi]), .mem_chipselect(mem_cs[gi]),
        .mem_write(mem_we[gi]), .mem_writedata(mem_wd[gi]), .mem_clken(mem_ck[gi]),
        .mem_readdata(mem_rd[gi])
      );

      // Single-port RAM: registered inputs, unregistered output.
      initial for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      always @(posedge clk) begin
        if (mem_cs[gi] && mem_we[gi]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[gi][b]) ram[mem_addr[gi]][8*b +: 8] <= mem_wd[gi][8*b +: 8];
          end
        end
        addr_q <= mem_addr[gi];
      end
      assign mem_rd[gi] = ram[addr_q];
    end
  endgenerate

  // Reference model state, one copy per instance (index = FIXED_PRIO value).
  bit          mdl_active [2];
  bit          mdl_last [2];
  bit          mdl_rdv [2][2];
  logic [31:0] mdl_rdata [2][2];
  logic [31:0] mdl_mem [2][1024];
  int          n_cmp = 0;
  int          n_err = 0;

  // Returns -1 for no grant, else the granted master index.
  function automatic int exp_grant(int d);
    bit q0 = m0_read | m0_write;
    bit q1 = m1_read | m1_write;
    if (reset || !mdl_active[d]) return -1;
    if (q0 && q1) begin
      if (d == 1) return 0;
      return (mdl_last[d] == 1'b1) ? 0 : 1;
    end
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_active[d] = 1'b0;
      mdl_last[d]   = 1'b1;
      mdl_rdv[d][0] = 1'b0;
      mdl_rdv[d][1] = 1'b0;
    end
  endtask

  // Advance the model across the next rising edge, then move 1 time unit past it.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int g = exp_grant(d);
      mdl_rdv[d][0] = 1'b0;
      mdl_rdv[d][1] = 1'b0;
      if (g >= 0) begin
        logic        rd  = (g == 0) ? m0_read : m1_read;
        logic        wr  = (g == 0) ? m0_write : m1_write;
        logic [9:0]  a   = (g == 0) ? m0_address : m1_address;
        logic [3:0]  be  = (g == 0) ? m0_byteenable : m1_byteenable;
        logic [31:0] wd  = (g == 0) ? m0_writedata : m1_writedata;
        mdl_last[d] = g[0];
        if (wr) begin
          for (int b = 0; b < 4; b++) if (be[b]) mdl_mem[d][a][8*b +: 8] = wd[8*b +: 8];
        end else if (rd) begin
          mdl_rdv[d][g]   = 1'b1;
          mdl_rdata[d][g] = mdl_mem[d][a];
        end
      end
      mdl_active[d] = !reset;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit r0, input bit w0, input logic [9:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input bit r1, input bit w1, input logic [9:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
  endtask

  task automatic idle();
    apply(0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b1 || wt1[d] !== 1'b1) begin
        n_err++; $display("FAIL reset_wait dut%0d: got %b/%b want 1/1", d, wt0[d], wt1[d]);
      end
      n_cmp++;
      if (mem_cs[d] !== 1'b0 || rv0[d] !== 1'b0 || rv1[d] !== 1'b0) begin
        n_err++; $display("FAIL reset_cs_rdv dut%0d: cs=%b rdv=%b%b want 0,00", d, mem_cs[d], rv0[d], rv1[d]);
      end
      n_cmp++;
      if (mem_ck[d] !== 1'b1) begin
        n_err++; $display("FAIL clken dut%0d: got %b want 1", d, mem_ck[d]);
      end
    end
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (mem_cs[d] !== 1'b0) begin
        n_err++; $display("FAIL idle_cs dut%0d: got %b want 0", d, mem_cs[d]);
      end
    end
    tick();
    // A request during the inactive first cycle must stall.
    do_reset();
    apply(1, 0, 10'h000, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b1) begin
        n_err++; $display("FAIL inactive_wait dut%0d: got %b want 1", d, wt0[d]);
      end
    end
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b0) begin
        n_err++; $display("FAIL active_accept dut%0d: got %b want 0", d, wt0[d]);
      end
    end
    tick();
    idle();
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    apply(0, 1, 10'h010, 4'hF, 32'hDEADBEEF, 0, 0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b0 || mem_we[d] !== 1'b1 || mem_addr[d] !== 10'h010 || mem_wd[d] !== 32'hDEADBEEF) begin
        n_err++; $display("FAIL wr_issue dut%0d: wait=%b we=%b addr=%h wd=%h want 0 1 010 deadbeef",
                          d, wt0[d], mem_we[d], mem_addr[d], mem_wd[d]);
      end
    end
    tick();
    apply(1, 0, 10'h010, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b0 || mem_we[d] !== 1'b0 || rv0[d] !== 1'b0) begin
        n_err++; $display("FAIL rd_issue dut%0d: wait=%b we=%b rdv=%b want 0 0 0", d, wt0[d], mem_we[d], rv0[d]);
      end
    end
    tick();
    idle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rv0[d] !== 1'b1 || rd0[d] !== 32'hDEADBEEF || rv1[d] !== 1'b0) begin
        n_err++; $display("FAIL rd_return dut%0d: rdv0=%b data=%h rdv1=%b want 1 deadbeef 0", d, rv0[d], rd0[d], rv1[d]);
      end
    end
    tick();
    $display("test_write_read done");
  endtask

  task automatic preload_rr();
    apply(0, 1, 10'h001, 4'hF, 32'h000000A1, 0, 0, 10'h0, 4'h0, 32'h0);
    tick();
    apply(0, 0, 10'h0, 4'h0, 32'h0, 0, 1, 10'h002, 4'hF, 32'h000000B2);
    tick();
    idle();
    do_reset();
    tick();
  endtask

  task automatic test_round_robin();
    preload_rr();
    for (int k = 0; k < 6; k++) begin
      int g = k % 2;
      apply(1, 0, 10'h001, 4'hF, 32'h0, 1, 0, 10'h002, 4'hF, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (wt0[0] !== (g != 0) || wt1[0] !== (g != 1)) begin
        n_err++; $display("FAIL rr_grant cyc%0d: wait=%b%b want m%0d granted", k, wt0[0], wt1[0], g);
      end
      if (k > 0) begin
        n_cmp++;
        if (g == 1 && (rv0[0] !== 1'b1 || rd0[0] !== 32'hA1 || rv1[0] !== 1'b0)) begin
          n_err++; $display("FAIL rr_rdv cyc%0d: rdv=%b%b data=%h want m0 a1", k, rv0[0], rv1[0], rd0[0]);
        end else if (g == 0 && (rv1[0] !== 1'b1 || rd1[0] !== 32'hB2 || rv0[0] !== 1'b0)) begin
          n_err++; $display("FAIL rr_rdv cyc%0d: rdv=%b%b data=%h want m1 b2", k, rv0[0], rv1[0], rd1[0]);
        end
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (rv1[0] !== 1'b1 || rd1[0] !== 32'hB2 || rv0[0] !== 1'b0) begin
      n_err++; $display("FAIL rr_tail: rdv=%b%b data=%h want m1 b2", rv0[0], rv1[0], rd1[0]);
    end
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_fixed_prio();
    preload_rr();
    for (int k = 0; k < 7; k++) begin
      bit both = (k < 6);
      apply(both, 0, 10'h001, 4'hF, 32'h0, 1, 0, 10'h002, 4'hF, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (wt0[1] !== !both || wt1[1] !== both) begin
        n_err++; $display("FAIL fp_grant cyc%0d: wait=%b%b want %b%b", k, wt0[1], wt1[1], !both, both);
      end
      if (k > 0) begin
        n_cmp++;
        if (rv0[1] !== 1'b1 || rd0[1] !== 32'hA1 || rv1[1] !== 1'b0) begin
          n_err++; $display("FAIL fp_rdv cyc%0d: rdv=%b%b data=%h want m0 a1", k, rv0[1], rv1[1], rd0[1]);
        end
      end
      tick();
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (rv1[1] !== 1'b1 || rd1[1] !== 32'hB2 || rv0[1] !== 1'b0) begin
      n_err++; $display("FAIL fp_tail: rdv=%b%b data=%h want m1 b2", rv0[1], rv1[1], rd1[1]);
    end
    tick();
    $display("test_fixed_prio done");
  endtask

  task automatic test_byte_write();
    apply(0, 0, 10'h0, 4'h0, 32'h0, 0, 1, 10'h3FF, 4'hF, 32'h11223344);
    tick();
    apply(0, 0, 10'h0, 4'h0, 32'h0, 0, 1, 10'h3FF, 4'h2, 32'h0000AB00);
    tick();
    apply(0, 0, 10'h0, 4'h0, 32'h0, 1, 0, 10'h3FF, 4'hF, 32'h0);
    tick();
    idle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rv1[d] !== 1'b1 || rd1[d] !== 32'h1122AB44) begin
        n_err++; $display("FAIL byte_write dut%0d: rdv=%b data=%h want 1 1122ab44", d, rv1[d], rd1[d]);
      end
    end
    tick();
    $display("test_byte_write done");
  endtask

  task automatic test_reset_mid_read();
    apply(1, 0, 10'h010, 4'hF, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (wt0[0] !== 1'b0) begin
      n_err++; $display("FAIL rmr_accept: wait=%b want 0", wt0[0]);
    end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (wt0[0] !== 1'b1 || mem_cs[0] !== 1'b0) begin
      n_err++; $display("FAIL rmr_async: wait=%b cs=%b want 1 0", wt0[0], mem_cs[0]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (rv0[d] !== 1'b0) begin
        n_err++; $display("FAIL rmr_rdv dut%0d: got %b want 0", d, rv0[d]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (wt0[d] !== 1'b1 || rv0[d] !== 1'b0) begin
        n_err++; $display("FAIL rmr_inactive dut%0d: wait=%b rdv=%b want 1 0", d, wt0[d], rv0[d]);
      end
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (wt0[0] !== 1'b0) begin
      n_err++; $display("FAIL rmr_reaccept: wait=%b want 0", wt0[0]);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rv0[0] !== 1'b1 || rd0[0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL rmr_return: rdv=%b data=%h want 1 deadbeef", rv0[0], rd0[0]);
    end
    tick();
    $display("test_reset_mid_read done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int k0 = $urandom_range(0, 4);
      int k1 = $urandom_range(0, 4);
      apply(k0 == 1 || k0 == 3 || k0 == 4, k0 == 2 || k0 == 3, 10'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom,
            k1 == 1 || k1 == 3 || k1 == 4, k1 == 2 || k1 == 3, 10'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int g = exp_grant(d);
        n_cmp++;
        if (wt0[d] !== (g != 0) || wt1[d] !== (g != 1) || mem_cs[d] !== (g >= 0)) begin
          n_err++; $display("FAIL rnd_grant dut%0d cyc%0d: wait=%b%b cs=%b want grant %0d",
                            d, c, wt0[d], wt1[d], mem_cs[d], g);
        end
        if (g >= 0) begin
          logic        ew = (g == 0) ? m0_write : m1_write;
          logic [9:0]  ea = (g == 0) ? m0_address : m1_address;
          logic [3:0]  eb = (g == 0) ? m0_byteenable : m1_byteenable;
          logic [31:0] ed = (g == 0) ? m0_writedata : m1_writedata;
          n_cmp++;
          if (mem_we[d] !== ew || mem_addr[d] !== ea || mem_be[d] !== eb || (ew && mem_wd[d] !== ed)) begin
            n_err++; $display("FAIL rnd_mem dut%0d cyc%0d: we=%b a=%h be=%h wd=%h want %b %h %h %h",
                              d, c, mem_we[d], mem_addr[d], mem_be[d], mem_wd[d], ew, ea, eb, ed);
          end
        end
        n_cmp++;
        if (rv0[d] !== mdl_rdv[d][0] || rv1[d] !== mdl_rdv[d][1]) begin
          n_err++; $display("FAIL rnd_rdv dut%0d cyc%0d: got %b%b want %b%b",
                            d, c, rv0[d], rv1[d], mdl_rdv[d][0], mdl_rdv[d][1]);
        end
        if (mdl_rdv[d][0]) begin
          n_cmp++;
          if (rd0[d] !== mdl_rdata[d][0]) begin
            n_err++; $display("FAIL rnd_rd0 dut%0d cyc%0d: got %h want %h", d, c, rd0[d], mdl_rdata[d][0]);
          end
        end
        if (mdl_rdv[d][1]) begin
          n_cmp++;
          if (rd1[d] !== mdl_rdata[d][1]) begin
            n_err++; $display("FAIL rnd_rd1 dut%0d cyc%0d: got %h want %h", d, c, rd1[d], mdl_rdata[d][1]);
          end
        end
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) mdl_mem[d][i] = 32'h0;
    model_reset();
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_prio();
    test_byte_write();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
